// File: rtl/mixcolumns.sv
`timescale 1ns/1ps
// mixcolumns: iterative AES MixColumns / InvMixColumns stage.
// A 128-bit state is captured on start_i (in IDLE). One 32-bit column is
// transformed per clock, column 0 first. ready_o pulses for one cycle when
// all four columns are done.
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-low; clears all registers
//   start_i    begin a transform (sampled only in IDLE)
//   decrypt_i  0 = MixColumns, 1 = InvMixColumns (sampled with start_i)
//   data_i     input state, column c = data_i[127-32c -: 32], row 0 = MSB byte
//   ready_o    registered one-cycle pulse, data_o holds a valid result
//   data_o     working/result register, partially transformed while busy
module mixcolumns (
  input  logic         clk,
  input  logic         reset,
  input  logic         start_i,
  input  logic         decrypt_i,
  input  logic [127:0] data_i,
  output logic         ready_o,
  output logic [127:0] data_o
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] COL0 = 3'd1;
  localparam logic [2:0] COL1 = 3'd2;
  localparam logic [2:0] COL2 = 3'd3;
  localparam logic [2:0] COL3 = 3'd4;

  logic [2:0]   state;
  logic [127:0] work;
  logic         dec_q;
  logic [31:0]  cur_col;
  logic [31:0]  new_col;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    xtime = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul3(input logic [7:0] x);
    mul3 = xtime(x) ^ x;
  endfunction

  function automatic logic [7:0] mul9(input logic [7:0] x);
    mul9 = x ^ xtime(xtime(xtime(x)));
  endfunction

  function automatic logic [7:0] mulb(input logic [7:0] x);
    logic [7:0] x2;
    x2   = xtime(x);
    mulb = x ^ x2 ^ xtime(xtime(x2));
  endfunction

  function automatic logic [7:0] muld(input logic [7:0] x);
    logic [7:0] x4;
    x4   = xtime(xtime(x));
    muld = x ^ x4 ^ xtime(x4);
  endfunction

  function automatic logic [7:0] mule(input logic [7:0] x);
    logic [7:0] x2;
    logic [7:0] x4;
    x2   = xtime(x);
    x4   = xtime(x2);
    mule = x2 ^ x4 ^ xtime(x4);
  endfunction

  function automatic logic [31:0] fwd_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    fwd_col = {xtime(a0) ^ mul3(a1) ^ a2 ^ a3,
               a0 ^ xtime(a1) ^ mul3(a2) ^ a3,
               a0 ^ a1 ^ xtime(a2) ^ mul3(a3),
               mul3(a0) ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [31:0] inv_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    inv_col = {mule(a0) ^ mulb(a1) ^ muld(a2) ^ mul9(a3),
               mul9(a0) ^ mule(a1) ^ mulb(a2) ^ muld(a3),
               muld(a0) ^ mul9(a1) ^ mule(a2) ^ mulb(a3),
               mulb(a0) ^ muld(a1) ^ mul9(a2) ^ mule(a3)};
  endfunction

  // Select the column owned by the current state and run it through the GF network
  always_comb begin
    cur_col = work[127:96];
    case (state)
      COL0:    cur_col = work[127:96];
      COL1:    cur_col = work[95:64];
      COL2:    cur_col = work[63:32];
      COL3:    cur_col = work[31:0];
      default: cur_col = work[127:96];
    endcase
    if (dec_q) begin
      new_col = inv_col(cur_col);
    end else begin
      new_col = fwd_col(cur_col);
    end
  end

  // Sequencer: capture on start, rewrite one column per cycle, pulse ready at the end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      work    <= 128'd0;
      dec_q   <= 1'b0;
      ready_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ready_o <= 1'b0;
          if (start_i) begin
            work  <= data_i;
            dec_q <= decrypt_i;
            state <= COL0;
          end
        end
        COL0: begin
          work[127:96] <= new_col;
          state        <= COL1;
        end
        COL1: begin
          work[95:64] <= new_col;
          state       <= COL2;
        end
        COL2: begin
          work[63:32] <= new_col;
          state       <= COL3;
        end
        COL3: begin
          work[31:0] <= new_col;
          state      <= IDLE;
          ready_o    <= 1'b1;
        end
        default: begin
          state   <= IDLE;
          ready_o <= 1'b0;
        end
      endcase
    end
  end

  assign data_o = work;

endmodule

// File: tb/tb_mixcolumns.sv
`timescale 1ns/1ps
// Self-checking bench for mixcolumns: directed FIPS-197 vectors, column edge
// cases, busy-input immunity, back-to-back starts, mid-transform reset and a
// randomized forward/inverse round trip against a generic GF(2^8) matrix model.
module tb_mixcolumns;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start_i = 1'b0;
  logic         decrypt_i = 1'b0;
  logic [127:0] data_i = 128'd0;
  logic         ready_o;
  logic [127:0] data_o;

  int n_vec  = 0;
  int n_miss = 0;

  mixcolumns dut (
    .clk       (clk),
    .reset     (reset),
    .start_i   (start_i),
    .decrypt_i (decrypt_i),
    .data_i    (data_i),
    .ready_o   (ready_o),
    .data_o    (data_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Generic shift-and-add GF(2^8) multiply modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    logic       hi;
    a = a_in; b = b_in; p = 8'd0;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = a << 1;
      if (hi) a = a ^ 8'h1b;
      b = b >> 1;
    end
    return p;
  endfunction

  // Circulant matrix product applied to each column of the state
  function automatic logic [127:0] ref_mix(input logic [127:0] s, input logic dec);
    logic [7:0]   coef [4];
    logic [7:0]   acc;
    logic [127:0] r;
    if (dec) begin
      coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
    end else begin
      coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
    end
    r = 128'd0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        acc = 8'd0;
        for (int j = 0; j < 4; j++)
          acc = acc ^ gmul(coef[(j - row + 4) % 4], s[127 - 32*c - 8*j -: 8]);
        r[127 - 32*c - 8*row -: 8] = acc;
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Start one transform and wait (bounded) for ready; lat = -1 on timeout
  task automatic run_op(input logic [127:0] din, input logic dec,
                        output logic [127:0] dout, output int lat);
    @(negedge clk);
    start_i = 1'b1; decrypt_i = dec; data_i = din;
    @(posedge clk); #1;
    start_i = 1'b0;
    lat = -1;
    for (int i = 1; i <= 10 && lat < 0; i++) begin
      @(posedge clk); #1;
      if (ready_o) lat = i;
    end
    dout = data_o;
  endtask

  logic [127:0] res, res2, r, exp1, exp2;
  int           lat, pulses, gap;

  initial begin
    // Reset held with start asserted: nothing may happen
    reset = 1'b0; start_i = 1'b1; data_i = rand128();
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {127'd0, ready_o}, 128'd0);
    check("rst_data", data_o, 128'd0);
    @(negedge clk);
    reset = 1'b1; start_i = 1'b0;
    pulses = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (ready_o) pulses++;
    end
    check("idle_no_ready", 128'(pulses), 128'd0);
    check("idle_data", data_o, 128'd0);

    // FIPS-197 forward vector, latency and pulse width
    run_op(128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b0, res, lat);
    check("fips_fwd_lat", 128'(lat), 128'd4);
    check("fips_fwd", res, 128'h046681e5e0cb199a48f8d37a2806264c);
    @(posedge clk); #1;
    check("ready_width", {127'd0, ready_o}, 128'd0);
    check("data_hold", data_o, 128'h046681e5e0cb199a48f8d37a2806264c);

    // Inverse vector
    run_op(128'h046681e5e0cb199a48f8d37a2806264c, 1'b1, res, lat);
    check("fips_inv_lat", 128'(lat), 128'd4);
    check("fips_inv", res, 128'hd4bf5d30e0b452aeb84111f11e2798e5);

    // Column edge cases
    run_op(128'hdb135345f20a225c01010101c6c6c6c6, 1'b0, res, lat);
    check("edge_cols", res, 128'h8e4da1bc9fdc589d01010101c6c6c6c6);

    // Busy-input immunity, then a start in the ready cycle
    r    = rand128();
    exp1 = ref_mix(r, 1'b0);
    @(negedge clk);
    start_i = 1'b1; decrypt_i = 1'b0; data_i = r;
    @(posedge clk); #1;
    pulses = 0;
    for (int i = 1; i <= 4; i++) begin
      start_i = ~start_i; decrypt_i = ~decrypt_i; data_i = rand128();
      @(posedge clk); #1;
      if (ready_o) pulses++;
    end
    check("busy_pulses", 128'(pulses), 128'd1);
    check("busy_ready_e4", {127'd0, ready_o}, 128'd1);
    check("busy_result", data_o, exp1);
    r    = rand128();
    exp2 = ref_mix(r, 1'b1);
    start_i = 1'b1; decrypt_i = 1'b1; data_i = r;
    @(posedge clk); #1;
    start_i = 1'b0;
    check("b2b_ready_fall", {127'd0, ready_o}, 128'd0);
    gap = -1;
    for (int i = 2; i <= 12 && gap < 0; i++) begin
      @(posedge clk); #1;
      if (ready_o) gap = i;
    end
    check("b2b_gap", 128'(gap), 128'd5);
    check("b2b_result", data_o, exp2);

    // Reset in the middle of a transform (state COL2)
    r = rand128();
    @(negedge clk);
    start_i = 1'b1; decrypt_i = 1'b0; data_i = r;
    @(posedge clk); #1;
    start_i = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("midrst_data", data_o, 128'd0);
    check("midrst_ready", {127'd0, ready_o}, 128'd0);
    @(negedge clk);
    reset = 1'b1;
    run_op(r, 1'b0, res, lat);
    check("post_rst_lat", 128'(lat), 128'd4);
    check("post_rst_result", res, ref_mix(r, 1'b0));

    // Random round trip against the model
    for (int n = 0; n < 1000; n++) begin
      r = rand128();
      run_op(r, 1'b0, res, lat);
      check("rand_fwd_lat", 128'(lat), 128'd4);
      check("rand_fwd", res, ref_mix(r, 1'b0));
      run_op(res, 1'b1, res2, lat);
      check("rand_inv_lat", 128'(lat), 128'd4);
      check("rand_roundtrip", res2, r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/mixcolumns.md
# mixcolumns

Iterative MixColumns / InvMixColumns stage of the AES round datapath, placed directly downstream of the combined SubBytes/ShiftRows stage. It accepts a 128-bit state on a start pulse and processes one 32-bit column per clock in GF(2^8). It returns the transformed state with a one-cycle ready pulse. The round controller bypasses it in the final round.

## Interface
- No parameters; all widths are fixed by AES-128.
- clk  input  1  single clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-low; clears every register immediately
- start_i  input  1  begin a transform; sampled only in IDLE
- decrypt_i  input  1  0 = MixColumns, 1 = InvMixColumns; sampled together with start_i
- data_i  input  128  input state; byte 0 = data_i[127:120], column c = data_i[127-32c -: 32], row 0 = MSB byte of the column
- ready_o  output  1  registered one-cycle pulse: data_o holds a valid result
- data_o  output  128  working/result register, driven continuously

## Operation
- Registers:
  - state: IDLE, COL0, COL1, COL2, COL3
  - work[127:0]
  - dec_q (latched mode)
  - ready_o
- Reset values: state=IDLE, work=0, dec_q=0, ready_o=0. data_o therefore reads 0 after reset.
- IDLE:
  - If start_i=1: work←data_i, dec_q←decrypt_i, state→COL0.
  - Otherwise all registers hold.
- COLk (k=0..3):
  - Column k of work is replaced by its transform; the other columns hold.
  - state advances COLk→COL(k+1).
  - COL3→IDLE, and ready_o←1 on that same edge.
- ready_o is 1 for exactly one cycle, then returns to 0. It is never asserted outside the COL3→IDLE transition.
- Forward column transform, with input column (a0,a1,a2,a3):
  - b0 = 2a0^3a1^a2^a3
  - b1 = a0^2a1^3a2^a3
  - b2 = a0^a1^2a2^3a3
  - b3 = 3a0^a1^a2^2a3
- Inverse column transform:
  - b0 = 0e·a0^0b·a1^0d·a2^09·a3, with the coefficient row rotated right by one for each of b1..b3
- GF arithmetic rules:
  - xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1b : 8'h00). All products are built from xtime chains and XOR; no carries and no width growth; every intermediate is 8 bits.
  - 3x = xtime(x)^x; 9x = x^x8; 0bx = x^x2^x8; 0dx = x^x4^x8; 0ex = x2^x4^x8, where x2=xtime(x), x4=xtime(x2), x8=xtime(x4).
- Boundary conditions:
  - start_i while busy (COL0..COL3): ignored. No restart, no effect on work or dec_q.
  - decrypt_i or data_i changing while busy: no effect, because both are latched at start.
  - start_i in the cycle ready_o=1 (state is IDLE): accepted. work is overwritten on that edge and ready_o falls.
  - data_o after completion: holds the result indefinitely until the next accepted start.
  - reset asserted mid-transform: immediate return to IDLE, work=0, ready_o=0. No partial result is ever flagged ready.

## Timing
- Edge E0: start_i sampled in IDLE.
- Edges E1..E4: columns 0..3 written.
- ready_o and the final data_o are valid in the cycle after E4. Latency is 4 cycles from start sample to ready.
- Throughput: one transform per 5 cycles. With back-to-back starts on ready, the next start is sampled at E5 (the cycle ready_o=1), giving a 5-cycle period.
- During COL states data_o shows a partially transformed state; consumers qualify it with ready_o only.
- Critical path: one column of inverse GF network (3 xtime levels plus a 4-input XOR tree), within a single cycle.

## Test plan
- Reset check: hold reset=0 with start_i=1 and random data_i -> ready_o=0, data_o=0, no state change. Release reset; idle with start_i=0 for 10 cycles -> no ready_o.
- FIPS-197 forward vector: data_i=d4bf5d30e0b452aeb84111f11e2798e5, decrypt_i=0, start pulse -> ready_o exactly 4 cycles later, for 1 cycle; data_o=046681e5e0cb199a48f8d37a2806264c.
- Inverse vector: data_i=046681e5e0cb199a48f8d37a2806264c, decrypt_i=1 -> data_o=d4bf5d30e0b452aeb84111f11e2798e5. Random-state round trip fwd→inv returns the original over 1000 vectors.
- Column edge cases, forward: columns db135345, f20a225c, 01010101, c6c6c6c6 packed in one state -> columns 8e4da1bc, 9fdc589d, 01010101, c6c6c6c6.
- Busy-input immunity: after start, toggle start_i, decrypt_i and data_i every cycle -> result identical to the unperturbed run; single ready pulse. Next start in the ready cycle is accepted, and the second ready arrives 5 cycles after the first.
- Mid-operation reset: assert reset during COL2 -> data_o=0 and ready_o=0 immediately. After release, a fresh start produces the correct result with 4-cycle latency.
